// File: rtl/ldpc_enc_sched_if.sv
// Bus between the payload sources / LDPC encoder and the frame scheduler.
// slave : scheduler view (takes requests and payload, drives encoder side).
// master: environment view (drives requests, payload, tags and encoder ready).
interface ldpc_enc_sched_if #(
    parameter int unsigned pDAT_W = 8,
    parameter int unsigned pTAG_W = 4,
    parameter int unsigned pREQ   = 2
);
    logic [pREQ-1:0]             ireq;
    logic [pREQ-1:0]             ival;
    logic [pREQ-1:0][pDAT_W-1:0] idat;
    logic [pREQ-1:0][pTAG_W-1:0] itag;
    logic [pREQ-1:0]             oack;
    logic [pREQ-1:0]             ogrant;
    logic                        obusy;
    logic                        ofrm_done;
    logic                        iordy;
    logic                        osop;
    logic                        oeop;
    logic                        oeof;
    logic                        oval;
    logic [pTAG_W-1:0]           otag;
    logic [pDAT_W-1:0]           odat;

    modport slave (
        input  ireq, ival, idat, itag, iordy,
        output oack, ogrant, obusy, ofrm_done, osop, oeop, oeof, oval, otag, odat
    );

    modport master (
        output ireq, ival, idat, itag, iordy,
        input  oack, ogrant, obusy, ofrm_done, osop, oeop, oeof, oval, otag, odat
    );
endinterface

// File: rtl/ldpc_enc_sched.sv
// Frame scheduler in front of the LDPC encoder.
// Round-robin arbitrates between pREQ payload sources, streams pDATA_NUM
// payload words from the winner, then pPAR_NUM zero parity beats, with
// sop/eop/eof framing. Encoder-side outputs are registered and only move
// when ld = iclkena & (~oval | iordy).
// Ports:
//   iclk, iresetn (async active-low), iclkena (global freeze when low)
//   bus.ireq/ival/idat/itag : per-source request, word valid, word, tag
//   bus.oack                : combinational word-taken strobe per source
//   bus.ogrant/obusy        : one-hot current owner / FSM not idle
//   bus.iordy               : encoder ready
//   bus.oval/osop/oeop/oeof/otag/odat/ofrm_done : registered encoder side
module ldpc_enc_sched #(
    parameter int unsigned pDAT_W    = 8,
    parameter int unsigned pTAG_W    = 4,
    parameter int unsigned pREQ      = 2,
    parameter int unsigned pDATA_NUM = 24,
    parameter int unsigned pPAR_NUM  = 24
) (
    input  logic                   iclk,
    input  logic                   iresetn,
    input  logic                   iclkena,
    ldpc_enc_sched_if.slave        bus
);
    localparam int unsigned IDX_W   = (pREQ > 1) ? $clog2(pREQ) : 1;
    localparam int unsigned CNT_MAX = (pDATA_NUM > pPAR_NUM) ? pDATA_NUM : pPAR_NUM;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(pDATA_NUM - 1);
    localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(pPAR_NUM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(pREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_gidx;
    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [pTAG_W-1:0] r_tag;
    logic [pREQ-1:0]   r_grant;
    logic              r_oval;
    logic              r_sop;
    logic              r_eop;
    logic              r_eof;
    logic              r_frm_done;
    logic [pTAG_W-1:0] r_otag;
    logic [pDAT_W-1:0] r_odat;

    logic              w_ld;
    logic              w_issue_d;
    logic              w_last_data;
    logic              w_last_par;
    logic [IDX_W-1:0]  w_gidx_nxt;
    logic [IDX_W-1:0]  w_start;
    logic [IDX_W-1:0]  w_cand;
    logic [IDX_W-1:0]  w_win;
    logic              w_any;

    assign w_ld        = iclkena & (~r_oval | bus.iordy);
    assign w_issue_d   = (r_state == ST_DATA) & w_ld & bus.ival[r_gidx];
    assign w_last_data = (r_cnt == DATA_LAST);
    assign w_last_par  = (r_cnt == PAR_LAST);
    assign w_gidx_nxt  = (r_gidx == IDX_LAST) ? '0 : r_gidx + IDX_W'(1);

    // Round-robin search; at the end of a frame the pointer update and the
    // rearbitration happen in the same cycle, so search from owner+1 directly.
    always_comb begin
        w_start = (r_state == ST_PAR) ? w_gidx_nxt : r_ptr;
        w_any   = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(pREQ); k++) begin
            w_cand = IDX_W'((int'(w_start) + k) % int'(pREQ));
            if (!w_any && bus.ireq[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // Word-taken strobe back to the owning source, same cycle as issue.
    always_comb begin
        bus.oack = '0;
        if (w_issue_d) begin
            bus.oack[r_gidx] = 1'b1;
        end
    end

    // Control FSM and registered encoder-side outputs.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            r_state    <= ST_IDLE;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_grant    <= '0;
            r_oval     <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_eof      <= 1'b0;
            r_frm_done <= 1'b0;
            r_otag     <= '0;
            r_odat     <= '0;
        end else if (iclkena) begin
            r_frm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ld) begin
                        r_oval <= 1'b0;
                        r_sop  <= 1'b0;
                        r_eop  <= 1'b0;
                        r_eof  <= 1'b0;
                    end
                    if (w_any) begin
                        r_gidx  <= w_win;
                        r_tag   <= bus.itag[w_win];
                        r_grant <= pREQ'(1) << w_win;
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_ld) begin
                        if (bus.ival[r_gidx]) begin
                            r_oval <= 1'b1;
                            r_odat <= bus.idat[r_gidx];
                            r_sop  <= (r_cnt == '0);
                            r_eop  <= w_last_data;
                            r_eof  <= 1'b0;
                            r_otag <= r_tag;
                            if (w_last_data) begin
                                r_cnt   <= '0;
                                r_state <= ST_PAR;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else begin
                            // source bubble
                            r_oval <= 1'b0;
                            r_sop  <= 1'b0;
                            r_eop  <= 1'b0;
                            r_eof  <= 1'b0;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_ld) begin
                        r_oval <= 1'b1;
                        r_odat <= '0;
                        r_sop  <= 1'b0;
                        r_eop  <= 1'b0;
                        r_eof  <= w_last_par;
                        r_otag <= r_tag;
                        if (w_last_par) begin
                            r_frm_done <= 1'b1;
                            r_cnt      <= '0;
                            r_ptr      <= w_gidx_nxt;
                            if (w_any) begin
                                r_gidx  <= w_win;
                                r_tag   <= bus.itag[w_win];
                                r_grant <= pREQ'(1) << w_win;
                                r_state <= ST_DATA;
                            end else begin
                                r_grant <= '0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ogrant    = r_grant;
    assign bus.obusy     = (r_state != ST_IDLE);
    assign bus.ofrm_done = r_frm_done;
    assign bus.oval      = r_oval;
    assign bus.osop      = r_sop;
    assign bus.oeop      = r_eop;
    assign bus.oeof      = r_eof;
    assign bus.otag      = r_otag;
    assign bus.odat      = r_odat;
endmodule

// File: tb/tb_ldpc_enc_sched.sv
// Scoreboard bench for ldpc_enc_sched (pREQ=2, 4 data + 4 parity beats).
module tb_ldpc_enc_sched;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned NR = 2;
    localparam int unsigned DN = 4;
    localparam int unsigned PN = 4;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic          eof;
        logic [TW-1:0] tag;
        logic [DW-1:0] dat;
    } beat_t;

    logic iclk    = 1'b0;
    logic iresetn = 1'b0;
    logic iclkena = 1'b0;

    ldpc_enc_sched_if #(.pDAT_W(DW), .pTAG_W(TW), .pREQ(NR)) bus ();

    ldpc_enc_sched #(
        .pDAT_W(DW), .pTAG_W(TW), .pREQ(NR), .pDATA_NUM(DN), .pPAR_NUM(PN)
    ) dut (
        .iclk    (iclk),
        .iresetn (iresetn),
        .iclkena (iclkena),
        .bus     (bus)
    );

    always #5 iclk = ~iclk;

    int            checks = 0;
    int            errors = 0;
    beat_t         exp_q[$];
    int            ack_q[$];
    int            n_src[NR];
    int            exp_n[NR];
    logic [NR-1:0] ack_pend = '0;
    int            done_cnt = 0;
    int            ack_cnt = 0;
    int            beat_cnt = 0;
    int            cyc = 0;
    int            first_cyc = -1;
    int            last_cyc = -1;
    int            frames = 0;
    logic [DW-1:0] base[NR];
    logic [TW-1:0] tags[NR];

    // Payload sources: the next word appears once the current one was acked.
    initial begin
        for (int s = 0; s < int'(NR); s++) n_src[s] = 0;
        bus.idat[0] = 8'h10;
        bus.idat[1] = 8'h80;
        forever begin
            @(posedge iclk);
            #1;
            for (int s = 0; s < int'(NR); s++) begin
                if (!iresetn) n_src[s] = 0;
                else if (ack_pend[s]) n_src[s]++;
                bus.idat[s] = base[s] + DW'(n_src[s]);
            end
            ack_pend = '0;
        end
    end

    // Monitor: compares every accepted encoder beat and every ack.
    always @(negedge iclk) begin
        beat_t         got;
        beat_t         exp;
        int            s;
        logic [NR-1:0] oh;
        cyc++;
        if (iresetn) begin
            if (!iclkena) begin
                checks++;
                if (bus.oack !== '0) begin
                    errors++;
                    $display("FAIL oack_frozen got %b want 00", bus.oack);
                end
            end else begin
                if (bus.oval) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                if (bus.oval && bus.iordy) begin
                    got.sop = bus.osop;
                    got.eop = bus.oeop;
                    got.eof = bus.oeof;
                    got.tag = bus.otag;
                    got.dat = bus.odat;
                    checks++;
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected got %h", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL beat got sop%b eop%b eof%b tag%h dat%h want sop%b eop%b eof%b tag%h dat%h",
                                     got.sop, got.eop, got.eof, got.tag, got.dat,
                                     exp.sop, exp.eop, exp.eof, exp.tag, exp.dat);
                        end
                    end
                end
                if (bus.ofrm_done) begin
                    done_cnt++;
                    checks++;
                    if (!(bus.oeof && bus.oval)) begin
                        errors++;
                        $display("FAIL frm_done_eof got eof%b val%b want 11", bus.oeof, bus.oval);
                    end
                end
                if (bus.oack !== '0) begin
                    ack_pend = bus.oack;
                    ack_cnt++;
                    checks++;
                    if (ack_q.size() == 0) begin
                        errors++;
                        $display("FAIL ack_unexpected got %b", bus.oack);
                    end else begin
                        s  = ack_q.pop_front();
                        oh = NR'(1) << s;
                        if (bus.oack !== oh || !bus.ival[s]) begin
                            errors++;
                            $display("FAIL ack got %b ival %b want %b with ival set", bus.oack, bus.ival, oh);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_frame(input int s);
        beat_t b;
        for (int k = 0; k < int'(DN); k++) begin
            b.sop = (k == 0);
            b.eop = (k == int'(DN) - 1);
            b.eof = 1'b0;
            b.tag = tags[s];
            b.dat = base[s] + DW'(exp_n[s]);
            exp_q.push_back(b);
            ack_q.push_back(s);
            exp_n[s]++;
        end
        for (int k = 0; k < int'(PN); k++) begin
            b.sop = 1'b0;
            b.eop = 1'b0;
            b.eof = (k == int'(PN) - 1);
            b.tag = tags[s];
            b.dat = '0;
            exp_q.push_back(b);
        end
        frames++;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!bus.obusy && n < 50) begin tick(); n++; end
        check({name, "_busy"}, 32'(bus.obusy), 32'd1);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin tick(); n++; end
        check({name, "_done"}, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (beat_cnt < target && n < 100) begin tick(); n++; end
        check({name, "_beats_reached"}, 32'(beat_cnt >= target), 32'd1);
    endtask

    task automatic begin_test();
        first_cyc = -1;
        last_cyc  = -1;
        ack_cnt   = 0;
        beat_cnt  = 0;
    endtask

    task automatic end_test(input string name, input int span, input int acks, input int beats);
        repeat (3) tick();
        check({name, "_expq_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_ackq_empty"}, 32'(ack_q.size()), 32'd0);
        check({name, "_acks"}, 32'(ack_cnt), 32'(acks));
        check({name, "_beats"}, 32'(beat_cnt), 32'(beats));
        if (span > 0) check({name, "_span"}, 32'(last_cyc - first_cyc + 1), 32'(span));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        base[0] = 8'h10;  base[1] = 8'h80;
        tags[0] = 4'h5;   tags[1] = 4'hA;
        exp_n[0] = 0;     exp_n[1] = 0;
        bus.ireq  = '0;
        bus.ival  = '1;
        bus.iordy = 1'b1;
        bus.itag[0] = 4'h5;
        bus.itag[1] = 4'hA;
        repeat (2) tick();

        // Reset state
        check("rst_oval", 32'(bus.oval), 32'd0);
        check("rst_osop", 32'(bus.osop), 32'd0);
        check("rst_oeop", 32'(bus.oeop), 32'd0);
        check("rst_oeof", 32'(bus.oeof), 32'd0);
        check("rst_odat", 32'(bus.odat), 32'd0);
        check("rst_otag", 32'(bus.otag), 32'd0);
        check("rst_ogrant", 32'(bus.ogrant), 32'd0);
        check("rst_obusy", 32'(bus.obusy), 32'd0);
        check("rst_frm_done", 32'(bus.ofrm_done), 32'd0);
        check("rst_oack", 32'(bus.oack), 32'd0);
        iresetn = 1'b1;
        iclkena = 1'b1;
        tick();

        // Single frame from source 0
        begin_test();
        push_frame(0);
        bus.ireq = 2'b01;
        wait_busy("single");
        check("single_grant", 32'(bus.ogrant), 32'd1);
        bus.ireq = 2'b00;
        wait_done(frames, "single");
        end_test("single", 8, 4, 8);

        // Round robin, both requesting; pointer is now past source 0
        begin_test();
        push_frame(1); push_frame(0); push_frame(1); push_frame(0);
        bus.ireq = 2'b11;
        n = 0;
        while (done_cnt < frames - 1 && n < 300) begin tick(); n++; end
        bus.ireq = 2'b00;
        wait_done(frames, "rr");
        end_test("rr", 32, 16, 32);

        // Encoder stall on the first parity beat
        begin_test();
        push_frame(0);
        bus.ireq = 2'b01;
        wait_busy("estall");
        bus.ireq = 2'b00;
        n = 0;
        while (!(bus.oval && bus.oeop) && n < 50) begin tick(); n++; end
        check("estall_eop_seen", 32'(bus.oeop), 32'd1);
        tick();
        bus.iordy = 1'b0;
        tick();
        bus.iordy = 1'b1;
        wait_done(frames, "estall");
        end_test("estall", 9, 4, 8);

        // Source stall: ival[0] toggling during the frame
        begin_test();
        push_frame(0);
        bus.ireq = 2'b01;
        wait_busy("sstall");
        bus.ireq = 2'b00;
        n = 0;
        while (done_cnt < frames && n < 300) begin
            bus.ival[0] = ~bus.ival[0];
            tick();
            n++;
        end
        bus.ival = '1;
        check("sstall_done", 32'(done_cnt), 32'(frames));
        end_test("sstall", 0, 4, 8);
        check("sstall_bubbles", 32'((last_cyc - first_cyc + 1) > 8), 32'd1);

        // Clock enable low for 3 cycles mid-DATA
        begin_test();
        push_frame(0);
        bus.ireq = 2'b01;
        wait_busy("clkena");
        bus.ireq = 2'b00;
        wait_beats(2, "clkena");
        iclkena = 1'b0;
        repeat (3) tick();
        iclkena = 1'b1;
        wait_done(frames, "clkena");
        end_test("clkena", 11, 4, 8);

        // Reset during parity aborts the frame
        begin_test();
        push_frame(1);
        bus.ireq = 2'b10;
        wait_busy("rstpar");
        bus.ireq = 2'b00;
        wait_beats(6, "rstpar");
        iresetn = 1'b0;
        #1;
        check("rstpar_oval", 32'(bus.oval), 32'd0);
        check("rstpar_oeof", 32'(bus.oeof), 32'd0);
        check("rstpar_odat", 32'(bus.odat), 32'd0);
        check("rstpar_otag", 32'(bus.otag), 32'd0);
        check("rstpar_ogrant", 32'(bus.ogrant), 32'd0);
        check("rstpar_obusy", 32'(bus.obusy), 32'd0);
        exp_q.delete();
        ack_q.delete();
        exp_n[0] = 0;
        exp_n[1] = 0;
        frames--;
        repeat (2) tick();
        iresetn = 1'b1;
        tick();
        check("rstpar_no_eof", 32'(done_cnt), 32'(frames));
        begin_test();
        push_frame(0);
        bus.ireq = 2'b11;
        wait_busy("postrst");
        check("postrst_grant", 32'(bus.ogrant), 32'd1);
        bus.ireq = 2'b00;
        wait_done(frames, "postrst");
        end_test("postrst", 8, 4, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
